random_delay_timer: RTL and testbench
=====================================

Name: random_delay_timer

Overview:
- Downstream consumer of the starting-line control FSM's delay request.
- When the FSM enters its DELAY phase and raises start, this block latches the current PRBS value and converts it to a bounded pseudo-random delay in ms ticks.
- It counts the delay down and returns a completion flag, which the FSM uses to go back to IDLE.
- Sits between the PRBS generator and the control FSM.

Parameters:
- PRBS_W, 16, width of the PRBS input.
- MIN_DELAY, 500, minimum delay in i_tick periods (ms).
- RANGE_LOG2, 10, number of low PRBS bits added to MIN_DELAY; random span is 0..2**RANGE_LOG2-1. Must be <= PRBS_W.
- CNT_W, $clog2(MIN_DELAY + 2**RANGE_LOG2), derived counter width; not overridden.

Ports:
- i_clk  input  1  system clock.
- i_arst_n  input  1  asynchronous active-low reset.
- i_tick  input  1  single-cycle ms enable, synchronous to i_clk.
- i_startDelay  input  1  level from the FSM; high for the whole DELAY phase.
- i_prbs  input  PRBS_W  current PRBS state; held stable while the FSM's PRBS enable is low.
- o_delayComplete  output  1  high while in DONE.
- o_busy  output  1  high in LOAD or COUNT.
- o_remaining  output  CNT_W  current countdown value, for debug and display.

Behaviour:
- Reset is asynchronous, active-low (i_arst_n) and applies to all flops. On reset: state=IDLE, counter=0, o_delayComplete=0, o_busy=0, o_remaining=0.
- States (package enum): IDLE, LOAD, COUNT, DONE.
- IDLE -> LOAD on a clock edge with i_startDelay=1. This is level-sensitive; no edge detect is needed because DONE gates re-entry.
- LOAD, one cycle:
  - counter <= MIN_DELAY + zero-extended i_prbs[RANGE_LOG2-1:0], computed at CNT_W width with no overflow by construction.
  - Next state is COUNT.
- COUNT:
  - On each i_tick: if counter==1, go to DONE with counter <= 0; else counter <= counter-1.
  - An i_tick during LOAD is ignored, so the first decrement comes from the first tick seen in COUNT.
  - Total latency from LOAD to DONE is N ticks, where N is the loaded value, plus at most 1 tick period of phase error, plus 2 clocks.
- DONE:
  - o_delayComplete=1.
  - DONE -> IDLE on the first clock with i_startDelay=0.
  - If i_startDelay stays high, remain in DONE. No retrigger without a low phase.
- i_startDelay falling while in LOAD or COUNT: go to IDLE next clock, counter <= 0, o_delayComplete never asserted.
- Counter value 0 in COUNT is unreachable because MIN_DELAY >= 1 is required; elaboration asserts MIN_DELAY >= 1.
- o_busy = (state==LOAD || state==COUNT). o_remaining = counter, registered.
- Mid-operation reset returns to IDLE immediately (asynchronous). No partial count survives.
- Wrap-around: the counter never decrements below 0; it is saturating by FSM construction.

Optional Feature:
- Macro: RANDOM_DELAY_ABORT_EN.
- Defined: adds port i_abort (input, 1 bit, false-start from the start button).
  - i_abort=1 in LOAD, COUNT or DONE forces IDLE next clock with counter <= 0.
  - o_delayComplete drops the following cycle.
  - i_abort in IDLE is ignored.
  - When i_abort and i_tick coincide with counter==1, abort wins and DONE is not entered.
- Undefined: no i_abort port; behaviour is as described above.

Decomposition:
- Package startline_pkg: ty_STATE_DELAY enum (logic [1:0]) and the elaboration-check constants for MIN_DELAY and RANGE_LOG2 limits.
- One sub-module, delay_downcounter:
  - Loadable CNT_W-bit down-counter with load, enable (tick) and clear inputs, and an output for is-one.
  - The FSM in random_delay_timer drives it.

Test Plan:
- Reset/idle: assert i_arst_n=0 mid-COUNT with counter=300 -> all outputs 0 immediately; after release, state IDLE.
- Nominal delay: MIN_DELAY=4, RANGE_LOG2=2, i_prbs=16'h0003, raise i_startDelay -> o_remaining=7 after LOAD; o_delayComplete rises on the clock after the 7th tick in COUNT.
- Minimum delay: i_prbs low bits=0 with MIN_DELAY=4 -> exactly 4 ticks; o_remaining sequence 4,3,2,1, then DONE.
- Hold in DONE: keep i_startDelay=1 for 20 clocks after DONE -> o_delayComplete stays 1 and no reload. Drop start -> IDLE next clock, o_delayComplete=0.
- Early withdrawal: drop i_startDelay at o_remaining=2 -> IDLE next clock; o_delayComplete never goes high.
- Abort (RANDOM_DELAY_ABORT_EN defined): pulse i_abort with o_remaining=1 in the same cycle as i_tick -> IDLE; o_delayComplete stays 0.

Source files
------------

// File: rtl/startline_pkg.sv
// Shared types and limits for the starting-line delay path.
// Optional abort support is selected by RANDOM_DELAY_ABORT_EN.
package startline_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_COUNT = 2'd2,
        S_DONE  = 2'd3
    } ty_STATE_DELAY;

    // Smallest legal minimum delay; zero would make COUNT reach 0
    localparam int unsigned MIN_DELAY_LO  = 1;
    // Random span needs at least one PRBS bit
    localparam int unsigned RANGE_LOG2_LO = 1;

endpackage

// File: rtl/delay_downcounter.sv
// Loadable saturating down-counter with clear, load and tick enable.
// Priority is clear, then load, then decrement.
module delay_downcounter #(
    parameter int unsigned CNT_W = 11
) (
    input  logic             clk,
    input  logic             arst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             en,
    input  logic             clr,
    output logic [CNT_W-1:0] count,
    output logic             is_one
);

    // Counter register; never decrements below zero
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en && (count != '0)) begin
            count <= count - CNT_W'(1);
        end
    end

    assign is_one = (count == CNT_W'(1));

endmodule

// File: rtl/random_delay_timer.sv
// Pseudo-random start delay: latches PRBS, counts ms ticks, flags done.
// Define RANDOM_DELAY_ABORT_EN to add the i_abort false-start input.
module random_delay_timer
    import startline_pkg::*;
#(
    parameter int unsigned PRBS_W     = 16,
    parameter int unsigned MIN_DELAY  = 500,
    parameter int unsigned RANGE_LOG2 = 10
) (
    input  logic                                       i_clk,
    input  logic                                       i_arst_n,
    input  logic                                       i_tick,
    input  logic                                       i_startDelay,
    input  logic [PRBS_W-1:0]                          i_prbs,
`ifdef RANDOM_DELAY_ABORT_EN
    input  logic                                       i_abort,
`endif
    output logic                                       o_delayComplete,
    output logic                                       o_busy,
    output logic [$clog2(MIN_DELAY+2**RANGE_LOG2)-1:0] o_remaining
);

    localparam int unsigned CNT_W = $clog2(MIN_DELAY + 2**RANGE_LOG2);

    if (MIN_DELAY < MIN_DELAY_LO) begin : g_bad_min
        $error("random_delay_timer: MIN_DELAY must be >= 1");
    end
    if (RANGE_LOG2 < RANGE_LOG2_LO || RANGE_LOG2 > PRBS_W) begin : g_bad_rng
        $error("random_delay_timer: RANGE_LOG2 out of range");
    end

    ty_STATE_DELAY    state;
    logic             abort;
    logic             quit;
    logic             ctr_load;
    logic             ctr_en;
    logic             ctr_clr;
    logic             ctr_one;
    logic [CNT_W-1:0] load_val;

`ifdef RANDOM_DELAY_ABORT_EN
    assign abort = i_abort;
`else
    assign abort = 1'b0;
`endif

    // Withdrawal or false start both drop back to IDLE
    assign quit     = abort || !i_startDelay;
    assign load_val = CNT_W'(MIN_DELAY)
                    + CNT_W'(i_prbs[RANGE_LOG2-1:0]);

    // Counter control derived from the current state
    always_comb begin
        ctr_load = 1'b0;
        ctr_en   = 1'b0;
        ctr_clr  = 1'b0;
        unique case (state)
            S_LOAD: begin
                if (quit) ctr_clr  = 1'b1;
                else      ctr_load = 1'b1;
            end
            S_COUNT: begin
                if (quit)          ctr_clr = 1'b1;
                else if (i_tick) begin
                    if (ctr_one)   ctr_clr = 1'b1;
                    else           ctr_en  = 1'b1;
                end
            end
            S_DONE: begin
                if (abort) ctr_clr = 1'b1;
            end
            default: ;
        endcase
    end

    delay_downcounter #(
        .CNT_W (CNT_W)
    ) u_ctr (
        .clk      (i_clk),
        .arst_n   (i_arst_n),
        .load     (ctr_load),
        .load_val (load_val),
        .en       (ctr_en),
        .clr      (ctr_clr),
        .count    (o_remaining),
        .is_one   (ctr_one)
    );

    // State machine with registered busy/complete flags
    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            state           <= S_IDLE;
            o_busy          <= 1'b0;
            o_delayComplete <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (i_startDelay) begin
                        state  <= S_LOAD;
                        o_busy <= 1'b1;
                    end
                end
                S_LOAD: begin
                    if (quit) begin
                        state  <= S_IDLE;
                        o_busy <= 1'b0;
                    end else begin
                        state  <= S_COUNT;
                    end
                end
                S_COUNT: begin
                    if (quit) begin
                        state  <= S_IDLE;
                        o_busy <= 1'b0;
                    end else if (i_tick && ctr_one) begin
                        state           <= S_DONE;
                        o_busy          <= 1'b0;
                        o_delayComplete <= 1'b1;
                    end
                end
                S_DONE: begin
                    if (quit) begin
                        state           <= S_IDLE;
                        o_delayComplete <= 1'b0;
                    end
                end
                default: begin
                    state           <= S_IDLE;
                    o_busy          <= 1'b0;
                    o_delayComplete <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_random_delay_timer.sv
// Directed bench for random_delay_timer with MIN_DELAY=4, RANGE_LOG2=2.
// Abort vectors run only when RANDOM_DELAY_ABORT_EN is defined.
module tb_random_delay_timer;

    logic        i_clk = 1'b0;
    logic        i_arst_n = 1'b0;
    logic        i_tick = 1'b0;
    logic        i_startDelay = 1'b0;
    logic [15:0] i_prbs = '0;
`ifdef RANDOM_DELAY_ABORT_EN
    logic        i_abort = 1'b0;
`endif
    logic        o_delayComplete;
    logic        o_busy;
    logic [2:0]  o_remaining;

    int n_checks = 0;
    int n_fail   = 0;

    random_delay_timer #(
        .PRBS_W     (16),
        .MIN_DELAY  (4),
        .RANGE_LOG2 (2)
    ) dut (
        .i_clk           (i_clk),
        .i_arst_n        (i_arst_n),
        .i_tick          (i_tick),
        .i_startDelay    (i_startDelay),
        .i_prbs          (i_prbs),
`ifdef RANDOM_DELAY_ABORT_EN
        .i_abort         (i_abort),
`endif
        .o_delayComplete (o_delayComplete),
        .o_busy          (o_busy),
        .o_remaining     (o_remaining)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic tick_once();
        i_tick = 1'b1;
        step();
        i_tick = 1'b0;
        step();
    endtask

    task automatic outs(input string tag, input int c, input int b,
                        input int r);
        check({tag, ".done"}, int'(o_delayComplete), c);
        check({tag, ".busy"}, int'(o_busy), b);
        check({tag, ".rem"}, int'(o_remaining), r);
    endtask

    initial begin
        #2;
        outs("reset", 0, 0, 0);
        step();
        i_arst_n = 1'b1;
        step();
        outs("idle", 0, 0, 0);

        // Nominal: 4 + 3 = 7 ticks; tick during LOAD ignored
        i_prbs = 16'h0003;
        i_startDelay = 1'b1;
        step();
        outs("load", 0, 1, 0);
        i_tick = 1'b1;
        step();
        i_tick = 1'b0;
        outs("nom.start", 0, 1, 7);
        for (int k = 0; k < 6; k++) tick_once();
        outs("nom.last", 0, 1, 1);
        i_tick = 1'b1;
        step();
        i_tick = 1'b0;
        outs("nom.done", 1, 0, 0);

        // Hold in DONE while start stays high
        for (int k = 0; k < 20; k++) begin
            tick_once();
            check("hold.done", int'(o_delayComplete), 1);
        end
        outs("hold.end", 1, 0, 0);
        i_startDelay = 1'b0;
        step();
        outs("release", 0, 0, 0);

        // Minimum delay: exactly 4 ticks
        i_prbs = 16'hFFF4;
        i_startDelay = 1'b1;
        step();
        step();
        outs("min.start", 0, 1, 4);
        tick_once();
        check("min.r3", int'(o_remaining), 3);
        tick_once();
        check("min.r2", int'(o_remaining), 2);
        tick_once();
        outs("min.r1", 0, 1, 1);
        tick_once();
        outs("min.done", 1, 0, 0);
        i_startDelay = 1'b0;
        step();
        outs("min.idle", 0, 0, 0);

        // Early withdrawal at remaining=2
        i_prbs = 16'h0003;
        i_startDelay = 1'b1;
        step();
        step();
        for (int k = 0; k < 5; k++) tick_once();
        check("wd.r2", int'(o_remaining), 2);
        i_startDelay = 1'b0;
        step();
        outs("wd.idle", 0, 0, 0);
        for (int k = 0; k < 3; k++) tick_once();
        outs("wd.stay", 0, 0, 0);

        // Asynchronous reset mid-count
        i_prbs = 16'h0001;
        i_startDelay = 1'b1;
        step();
        step();
        tick_once();
        check("rst.pre", int'(o_remaining), 4);
        #2;
        i_arst_n = 1'b0;
        #1;
        outs("rst.async", 0, 0, 0);
        i_startDelay = 1'b0;
        #1;
        i_arst_n = 1'b1;
        step();
        outs("rst.idle", 0, 0, 0);
        i_startDelay = 1'b1;
        step();
        outs("rst.reload", 0, 1, 0);
        i_startDelay = 1'b0;
        step();
        outs("rst.quit", 0, 0, 0);

`ifdef RANDOM_DELAY_ABORT_EN
        // Abort coincident with the final tick wins
        i_prbs = 16'h0000;
        i_startDelay = 1'b1;
        step();
        step();
        for (int k = 0; k < 3; k++) tick_once();
        check("ab.r1", int'(o_remaining), 1);
        i_abort = 1'b1;
        i_tick = 1'b1;
        step();
        i_abort = 1'b0;
        i_tick = 1'b0;
        outs("ab.idle", 0, 0, 0);
        i_startDelay = 1'b0;
        step();
        // Abort while in DONE drops complete
        i_startDelay = 1'b1;
        step();
        step();
        for (int k = 0; k < 4; k++) tick_once();
        check("ab.done", int'(o_delayComplete), 1);
        i_abort = 1'b1;
        step();
        i_abort = 1'b0;
        outs("ab.drop", 0, 0, 0);
        i_startDelay = 1'b0;
        step();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got 0 expected 1");
        $fatal(1, "timeout");
    end

endmodule
